// File: rtl/shot_command_parser_if.sv
// Handshake bundle between the keyboard front end, the shot parser and the board-update logic.
// The master side supplies scan codes and shot_ready; the slave side is the parser itself.
interface shot_command_parser_if;
    logic       key_valid;
    logic [7:0] key_code;
    logic       shot_ready;
    logic [3:0] letter;
    logic [3:0] number;
    logic       shot_valid;
    logic       player_turn;
    logic       key_error;
    logic [1:0] stage;

    modport master (
        output key_valid, key_code, shot_ready,
        input  letter, number, shot_valid, player_turn, key_error, stage
    );

    modport slave (
        input  key_valid, key_code, shot_ready,
        output letter, number, shot_valid, player_turn, key_error, stage
    );
endinterface

// File: rtl/shot_command_parser.sv
// PS/2 set-2 scan-code parser: letter, number, Enter -> one shot command with valid/ready handshake.
// Handles F0/E0 prefixes, Backspace/Escape editing and an idle timeout on partial commands.
module shot_command_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 135000000,
    parameter bit          FIRST_PLAYER   = 1'b0
) (
    input  logic                  clock27,
    input  logic                  resetn,
    shot_command_parser_if.slave  bus
);

    typedef enum logic [1:0] {
        GET_LETTER = 2'd0,
        GET_NUMBER = 2'd1,
        GET_ENTER  = 2'd2,
        ISSUE      = 2'd3
    } state_t;

    localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned      TO_LAST  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_LAST);

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_ENTER = 8'h5A;
    localparam logic [7:0] CODE_BKSP  = 8'h66;
    localparam logic [7:0] CODE_ESC   = 8'h76;

    function automatic logic [3:0] decode_letter(input logic [7:0] c);
        case (c)
            8'h1C:   return 4'd0;
            8'h32:   return 4'd1;
            8'h21:   return 4'd2;
            8'h23:   return 4'd3;
            8'h24:   return 4'd4;
            8'h2B:   return 4'd5;
            8'h34:   return 4'd6;
            8'h33:   return 4'd7;
            8'h43:   return 4'd8;
            8'h3B:   return 4'd9;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] decode_digit(input logic [7:0] c);
        case (c)
            8'h45:   return 4'd0;
            8'h16:   return 4'd1;
            8'h1E:   return 4'd2;
            8'h26:   return 4'd3;
            8'h25:   return 4'd4;
            8'h2E:   return 4'd5;
            8'h36:   return 4'd6;
            8'h3D:   return 4'd7;
            8'h3E:   return 4'd8;
            8'h46:   return 4'd9;
            default: return 4'hF;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       pend_l_q, pend_l_d;
    logic [3:0]       pend_n_q, pend_n_d;
    logic [3:0]       letter_q, letter_d;
    logic [3:0]       number_q, number_d;
    logic             shot_valid_q, shot_valid_d;
    logic             player_turn_q, player_turn_d;
    logic             key_error_q, key_error_d;
    logic             brk_q, brk_d;
    logic             ext_q, ext_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       make;
    logic       timeout_hit;
    logic [3:0] code_letter;
    logic [3:0] code_digit;
    logic       is_bksp;
    logic       is_esc;
    logic       is_enter;

    always_ff @(posedge clock27 or negedge resetn) begin
        if (!resetn) begin
            state_q       <= GET_LETTER;
            pend_l_q      <= 4'hF;
            pend_n_q      <= 4'hF;
            letter_q      <= 4'hF;
            number_q      <= 4'hF;
            shot_valid_q  <= 1'b0;
            player_turn_q <= FIRST_PLAYER;
            key_error_q   <= 1'b0;
            brk_q         <= 1'b0;
            ext_q         <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            pend_l_q      <= pend_l_d;
            pend_n_q      <= pend_n_d;
            letter_q      <= letter_d;
            number_q      <= number_d;
            shot_valid_q  <= shot_valid_d;
            player_turn_q <= player_turn_d;
            key_error_q   <= key_error_d;
            brk_q         <= brk_d;
            ext_q         <= ext_d;
            cnt_q         <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pend_l_d      = pend_l_q;
        pend_n_d      = pend_n_q;
        letter_d      = letter_q;
        number_d      = number_q;
        shot_valid_d  = shot_valid_q;
        player_turn_d = player_turn_q;
        key_error_d   = 1'b0;
        brk_d         = brk_q;
        ext_d         = ext_q;
        cnt_d         = cnt_q;
        make          = 1'b0;

        code_letter = decode_letter(bus.key_code);
        code_digit  = decode_digit(bus.key_code);
        is_bksp     = (bus.key_code == CODE_BKSP);
        is_esc      = (bus.key_code == CODE_ESC);
        is_enter    = (bus.key_code == CODE_ENTER);

        // A pending release swallows the next byte whatever it is, including another prefix.
        if (bus.key_valid) begin
            if (brk_q) begin
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else if (bus.key_code == CODE_BREAK) begin
                brk_d = 1'b1;
            end else if (bus.key_code == CODE_EXT) begin
                ext_d = 1'b1;
            end else if (ext_q) begin
                ext_d = 1'b0;
                make  = is_enter;
            end else begin
                make = 1'b1;
            end
        end

        timeout_hit = (TIMEOUT_CYCLES != 0) && !bus.key_valid &&
                      ((state_q == GET_NUMBER) || (state_q == GET_ENTER)) &&
                      (cnt_q == CNT_LAST);

        if (bus.key_valid || (state_q == GET_LETTER) || (state_q == ISSUE)) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            GET_LETTER: begin
                if (make) begin
                    if (code_letter != 4'hF) begin
                        pend_l_d = code_letter;
                        state_d  = GET_NUMBER;
                    end else if (!(is_bksp || is_esc)) begin
                        key_error_d = 1'b1;
                    end
                end
            end
            GET_NUMBER: begin
                if (make) begin
                    if (code_digit != 4'hF) begin
                        pend_n_d = code_digit;
                        state_d  = GET_ENTER;
                    end else if (is_bksp || is_esc) begin
                        state_d = GET_LETTER;
                    end else begin
                        key_error_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d     = GET_LETTER;
                    key_error_d = 1'b1;
                end
            end
            GET_ENTER: begin
                if (make) begin
                    if (is_enter) begin
                        letter_d     = pend_l_q;
                        number_d     = pend_n_q;
                        shot_valid_d = 1'b1;
                        state_d      = ISSUE;
                    end else if (is_bksp) begin
                        state_d = GET_NUMBER;
                    end else if (is_esc) begin
                        state_d = GET_LETTER;
                    end else begin
                        key_error_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d     = GET_LETTER;
                    key_error_d = 1'b1;
                end
            end
            ISSUE: begin
                if (shot_valid_q && bus.shot_ready) begin
                    shot_valid_d  = 1'b0;
                    player_turn_d = ~player_turn_q;
                    state_d       = GET_LETTER;
                end
            end
            default: state_d = GET_LETTER;
        endcase
    end

    assign bus.letter      = letter_q;
    assign bus.number      = number_q;
    assign bus.shot_valid  = shot_valid_q;
    assign bus.player_turn = player_turn_q;
    assign bus.key_error   = key_error_q;
    assign bus.stage       = state_q;

endmodule

// File: tb/tb_shot_command_parser.sv
// Randomized bench for shot_command_parser: a byte-level reference model predicts shots and
// key_error pulses into queues; a monitor pops and compares them as the DUT produces them.
module tb_shot_command_parser;

    localparam int unsigned TO = 16;
    localparam bit          FP = 1'b1;

    logic clock27 = 1'b0;
    logic resetn  = 1'b0;

    shot_command_parser_if bus();

    shot_command_parser #(
        .TIMEOUT_CYCLES(TO),
        .FIRST_PLAYER  (FP)
    ) dut (
        .clock27(clock27),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clock27 = ~clock27;

    typedef struct {
        int l;
        int n;
        int p;
    } shot_t;

    shot_t sb_q[$];
    int    err_q[$];
    shot_t mon_s;

    int checks   = 0;
    int failures = 0;

    logic [7:0] letter_codes [10] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B};
    logic [7:0] digit_codes  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    // Reference model: phase is the command step 0..3 (letter, number, enter, waiting for accept).
    int m_phase, m_pl, m_pn, m_turn, m_outl, m_outn;
    bit m_brk, m_ext;
    int idle;
    int cur_idx      = 0;
    int consumed_idx = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int find_code(input logic [7:0] b, input bit want_digit);
        for (int i = 0; i < 10; i++) begin
            if (!want_digit && letter_codes[i] == b) return i;
            if (want_digit && digit_codes[i] == b) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_outl  = 15;
        m_outn  = 15;
        m_pl    = 15;
        m_pn    = 15;
        m_brk   = 0;
        m_ext   = 0;
        m_turn  = FP;
        idle    = 0;
        sb_q.delete();
        err_q.delete();
    endtask

    task automatic model_idle_check();
        if ((m_phase == 1 || m_phase == 2) && idle >= TO) begin
            m_phase = 0;
            err_q.push_back(cur_idx);
        end
    endtask

    task automatic model_make(input logic [7:0] b);
        int li, di;
        shot_t s;
        li = find_code(b, 1'b0);
        di = find_code(b, 1'b1);
        case (m_phase)
            0: if (li >= 0) begin m_pl = li; m_phase = 1; end
               else if (b != 8'h66 && b != 8'h76) err_q.push_back(cur_idx);
            1: if (di >= 0) begin m_pn = di; m_phase = 2; end
               else if (b == 8'h66 || b == 8'h76) m_phase = 0;
               else err_q.push_back(cur_idx);
            2: if (b == 8'h5A) begin
                   m_outl = m_pl;
                   m_outn = m_pn;
                   s.l = m_pl; s.n = m_pn; s.p = m_turn;
                   sb_q.push_back(s);
                   m_phase = 3;
               end else if (b == 8'h66) m_phase = 1;
               else if (b == 8'h76) m_phase = 0;
               else err_q.push_back(cur_idx);
            default: ;
        endcase
    endtask

    task automatic model_byte(input logic [7:0] b);
        idle = 0;
        cur_idx++;
        if (m_brk) begin
            m_brk = 0;
            m_ext = 0;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (m_ext) begin
            m_ext = 0;
            if (b == 8'h5A) model_make(b);
        end else begin
            model_make(b);
        end
    endtask

    task automatic tick();
        @(posedge clock27);
        #2;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ":stage"}, int'(bus.stage), m_phase);
        chk({tag, ":shot_valid"}, int'(bus.shot_valid), int'(m_phase == 3));
        chk({tag, ":letter"}, int'(bus.letter), m_outl);
        chk({tag, ":number"}, int'(bus.number), m_outn);
        chk({tag, ":player_turn"}, int'(bus.player_turn), m_turn);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            idle++;
            model_idle_check();
        end
    endtask

    task automatic wait_accept();
        bit ok;
        ok = 0;
        bus.shot_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            idle++;
            if (!bus.shot_valid) begin
                ok = 1;
                break;
            end
        end
        bus.shot_ready = 1'b0;
        chk("accept_within_bound", int'(ok), 1);
        if (ok) begin
            m_phase = 0;
            m_turn  = m_turn ^ 1;
        end
        check_outputs("after_accept");
    endtask

    // force_ready: -1 random, 0 never, 1 always when this byte completes a command.
    task automatic send(input logic [7:0] b, input int force_ready);
        bit completes;
        bit rdy;
        completes = (m_phase == 2) && !m_brk && (b == 8'h5A);
        rdy = completes && ((force_ready == 1) || (force_ready < 0 && $urandom_range(0, 1) == 1));
        model_byte(b);
        bus.key_code   = b;
        bus.key_valid  = 1'b1;
        bus.shot_ready = rdy;
        tick();
        bus.key_valid = 1'b0;
        check_outputs("after_byte");
        if (rdy) wait_accept();
    endtask

    task automatic async_reset_check();
        #5;
        resetn = 1'b0;
        #1;
        chk("rst:stage", int'(bus.stage), 0);
        chk("rst:letter", int'(bus.letter), 15);
        chk("rst:number", int'(bus.number), 15);
        chk("rst:shot_valid", int'(bus.shot_valid), 0);
        chk("rst:key_error", int'(bus.key_error), 0);
        chk("rst:player_turn", int'(bus.player_turn), int'(FP));
        model_reset();
        tick();
        resetn = 1'b1;
    endtask

    function automatic logic [7:0] pick_byte();
        int r;
        r = $urandom_range(0, 99);
        if (r < 8)  return 8'hF0;
        if (r < 13) return 8'hE0;
        if (r < 20) return 8'($urandom_range(0, 255));
        if (r < 26) return 8'h66;
        if (r < 30) return 8'h76;
        case (m_phase)
            0: return letter_codes[$urandom_range(0, 9)];
            1: return digit_codes[$urandom_range(0, 9)];
            2: return 8'h5A;
            default: return ($urandom_range(0, 1) == 1) ? letter_codes[$urandom_range(0, 9)] : 8'h5A;
        endcase
    endfunction

    function automatic int pick_gap();
        int r;
        r = $urandom_range(0, 99);
        if (r < 70) return $urandom_range(0, 3);
        if (r < 85) return TO - 1;
        if (r < 95) return TO;
        return TO + 3;
    endfunction

    always @(posedge clock27) begin
        if (bus.key_valid) consumed_idx <= cur_idx;
    end

    always @(negedge clock27) begin
        if (resetn) begin
            if (bus.shot_valid && bus.shot_ready) begin
                chk("shot_expected", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    mon_s = sb_q.pop_front();
                    chk("shot_letter", int'(bus.letter), mon_s.l);
                    chk("shot_number", int'(bus.number), mon_s.n);
                    chk("shot_player", int'(bus.player_turn), mon_s.p);
                end
            end
            if (bus.key_error) begin
                chk("key_error_expected", int'(err_q.size() > 0), 1);
                if (err_q.size() > 0) chk("key_error_byte", consumed_idx, err_q.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required below 5000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.key_valid  = 1'b0;
        bus.key_code   = 8'h00;
        bus.shot_ready = 1'b0;
        model_reset();
        #23;
        chk("init:stage", int'(bus.stage), 0);
        chk("init:letter", int'(bus.letter), 15);
        chk("init:number", int'(bus.number), 15);
        chk("init:shot_valid", int'(bus.shot_valid), 0);
        chk("init:player_turn", int'(bus.player_turn), int'(FP));
        resetn = 1'b1;
        tick();

        // Basic command, ready already high when shot_valid rises.
        send(8'h33, 0); send(8'h16, 0); send(8'h5A, 1);
        chk("t1:letter", int'(bus.letter), 7);
        chk("t1:number", int'(bus.number), 1);
        idle_cycles(2);

        // Releases and extended Enter, shot held while ready stays low.
        send(8'h1C, 0); send(8'hF0, 0); send(8'h1C, 0); send(8'h45, 0);
        send(8'hF0, 0); send(8'h45, 0); send(8'hE0, 0); send(8'h5A, 0);
        for (int i = 0; i < 10; i++) begin
            idle_cycles(1);
            chk("t2:held_valid", int'(bus.shot_valid), 1);
        end
        chk("t2:letter", int'(bus.letter), 0);
        chk("t2:number", int'(bus.number), 0);
        wait_accept();

        // Illegal digit in letter state, Backspace and Escape editing.
        send(8'h16, 0); idle_cycles(1);
        send(8'h1C, 0); send(8'h66, 0);
        send(8'h1C, 0); send(8'h2E, 0); send(8'h76, 0);
        idle_cycles(2);

        // Timeout boundary: a key in the last cycle wins, a full idle window expires.
        send(8'h24, 0); idle_cycles(TO - 1);
        send(8'h16, 0); idle_cycles(TO);
        chk("t4:stage_after_timeout", int'(bus.stage), 0);
        idle_cycles(2);

        // Asynchronous reset mid-GET_ENTER and mid-ISSUE.
        send(8'h1C, 0); send(8'h16, 0); idle_cycles(1);
        async_reset_check();
        send(8'h1C, 0); send(8'h16, 0); send(8'h5A, 0); idle_cycles(1);
        async_reset_check();
        idle_cycles(1);

        // Keys during ISSUE are ignored; next command uses the toggled player.
        send(8'h1C, 0); send(8'h16, 0); send(8'h5A, 0);
        send(8'h1C, 0); send(8'h16, 0); send(8'h5A, 0);
        wait_accept();
        send(8'h21, 0); send(8'h26, 0); send(8'h5A, 0);
        wait_accept();

        for (int step = 0; step < 600; step++) begin
            if (m_phase == 3 && $urandom_range(0, 2) == 0) begin
                wait_accept();
            end else begin
                send(pick_byte(), -1);
                idle_cycles(pick_gap());
            end
        end
        if (m_phase == 3) wait_accept();
        idle_cycles(TO + 4);

        chk("end:shots_outstanding", sb_q.size(), 0);
        chk("end:errors_outstanding", err_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
